vmu_mem_responder: RTL

VMU_MEM_RESPONDER -- requirements
Module: vmu_mem_responder

---
 rtl/cellrv32_package.sv | 39 +++
 rtl/vmu_resp_fifo.sv | 58 +++++
 rtl/vmu_mem_responder.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/cellrv32_package.sv
// ============================================================================
// Module      : cellrv32_package
// Description : Shared VMU memory request/response types, microop opcodes
//               and the responder FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package cellrv32_package;

   localparam int VMU_ADDR_W   = 32;
   localparam int VMU_DATA_W   = 32;
   localparam int VMU_TICKET_W = 4;
   localparam int VMU_UOP_W    = 7;

   localparam logic [VMU_UOP_W-1:0] opcode_vload_c  = 7'b0000111;
   localparam logic [VMU_UOP_W-1:0] opcode_vstore_c = 7'b0100111;

   typedef struct packed {
      logic [VMU_ADDR_W-1:0]   addr;
      logic [VMU_UOP_W-1:0]    microop;
      logic [VMU_TICKET_W-1:0] ticket;
      logic [VMU_DATA_W-1:0]   data;
   } vector_mem_req;

   typedef struct packed {
      logic [VMU_TICKET_W-1:0] ticket;
      logic [VMU_DATA_W-1:0]   data;
   } vector_mem_resp;

   typedef enum logic [0:0] {
      VMU_RESP_IDLE  = 1'b0,
      VMU_RESP_ISSUE = 1'b1
   } vmu_resp_state_e;

endpackage

`default_nettype wire

// File: rtl/vmu_resp_fifo.sv
// ============================================================================
// Module      : vmu_resp_fifo
// Description : Synchronous power-of-two FIFO with occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module vmu_resp_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Storage carries no reset; occupancy alone defines validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

`default_nettype wire

// File: rtl/vmu_mem_responder.sv
// ============================================================================
// Module      : vmu_mem_responder
// Description : Buffers VMU requests and serialises them onto a simple
//               single-outstanding memory bus, returning load responses.
//               Optional macro CELLRV32_VMU_RESP_ERR_EN adds sticky error
//               reporting (err_o / err_addr_o).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module vmu_mem_responder
   import cellrv32_package::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int TICKET_WIDTH = 4,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_valid_i,
   input  vector_mem_req         req_i,
   output logic                  ready_o,
   output logic                  resp_valid_o,
   output vector_mem_resp        resp_o,
   output logic                  bus_req_o,
   output logic                  bus_we_o,
   output logic [ADDR_WIDTH-1:0] bus_addr_o,
   output logic [DATA_WIDTH-1:0] bus_wdata_o,
   input  logic                  bus_ack_i,
   input  logic [DATA_WIDTH-1:0] bus_rdata_i,
   input  logic                  bus_err_i,
`ifdef CELLRV32_VMU_RESP_ERR_EN
   output logic                  err_o,
   output logic [ADDR_WIDTH-1:0] err_addr_o,
`endif
   output logic                  idle_o
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   vmu_resp_state_e         state;
   vmu_resp_state_e         state_nxt;
   vector_mem_req           head;
   logic                    push;
   logic                    pop;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic [CNT_W-1:0]        fifo_count;
   logic                    head_load;
   logic                    head_store;
   logic                    head_mem;
   logic                    issuing;
   logic                    bus_done;
   logic [DATA_WIDTH-1:0]   load_data;
   logic [TICKET_WIDTH-1:0] resp_ticket;
   logic [DATA_WIDTH-1:0]   resp_data;

   vmu_resp_fifo #(
      .WIDTH ($bits(vector_mem_req)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (push),
      .wdata (req_i),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign ready_o    = ~fifo_full;
   assign push       = req_valid_i & ~fifo_full;
   assign head_load  = (head.microop == opcode_vload_c);
   assign head_store = (head.microop == opcode_vstore_c);
   assign head_mem   = head_load | head_store;
   assign issuing    = (state == VMU_RESP_ISSUE) & ~fifo_empty;

   // Bus outputs come straight from the FIFO head, so they stay stable
   // until the pop that follows the acknowledge.
   assign bus_req_o   = issuing & head_mem;
   assign bus_we_o    = bus_req_o & head_store;
   assign bus_addr_o  = bus_req_o ? ADDR_WIDTH'(head.addr) : '0;
   assign bus_wdata_o = bus_we_o  ? DATA_WIDTH'(head.data) : '0;
   assign bus_done    = bus_req_o & bus_ack_i;
   assign pop         = bus_done | (issuing & ~head_mem);
   assign idle_o      = fifo_empty & (state == VMU_RESP_IDLE);

   always_comb begin
      state_nxt = state;
      case (state)
         VMU_RESP_IDLE: begin
            if (!fifo_empty || push) state_nxt = VMU_RESP_ISSUE;
         end
         VMU_RESP_ISSUE: begin
            if (fifo_empty) begin
               state_nxt = VMU_RESP_IDLE;
            end else if (pop) begin
               state_nxt = (fifo_count > CNT_W'(1) || push) ? VMU_RESP_ISSUE
                                                            : VMU_RESP_IDLE;
            end
         end
         default: state_nxt = VMU_RESP_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= VMU_RESP_IDLE;
      else       state <= state_nxt;
   end

`ifdef CELLRV32_VMU_RESP_ERR_EN
   // A faulting load still completes, but with zeroed data.
   assign load_data = bus_err_i ? '0 : bus_rdata_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_o      <= 1'b0;
         err_addr_o <= '0;
      end else if (bus_done && bus_err_i && !err_o) begin
         err_o      <= 1'b1;
         err_addr_o <= bus_addr_o;
      end
   end
`else
   logic unused_bus_err;
   assign unused_bus_err = bus_err_i;
   assign load_data      = bus_rdata_i;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         resp_valid_o <= 1'b0;
         resp_ticket  <= '0;
         resp_data    <= '0;
      end else begin
         resp_valid_o <= bus_done & head_load;
         if (bus_done && head_load) begin
            resp_ticket <= TICKET_WIDTH'(head.ticket);
            resp_data   <= load_data;
         end
      end
   end

   always_comb begin
      resp_o        = '0;
      resp_o.ticket = VMU_TICKET_W'(resp_ticket);
      resp_o.data   = VMU_DATA_W'(resp_data);
   end

endmodule

`default_nettype wire
